cam_line_packetizer: RTL and testbench

Converts the 16-bit BGR565 pixel stream from the camera front end into header-tagged line segments on a valid/ready stream for the downstream UDP framer. It runs in the half-rate camera pixel clock domain and sits between the camera front end (vsync, de, data_bgr565) and the async FIFO that feeds the UDP/Ethernet stage. Each line is split into segments of at most PIX_PER_PKT pixels. A segment that cannot be buffered is dropped whole and counted.

---
 rtl/cam_pkt_pkg.sv | 22 ++
 rtl/cam_pkt_bank_ram.sv | 23 ++
 rtl/cam_line_packetizer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_cam_line_packetizer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkt_pkg.sv
// Shared constants, segment descriptor and FSM state types for the camera line packetizer.
package cam_pkt_pkg;

  localparam logic [15:0] HDR_MAGIC = 16'hA55A;
  localparam int          HDR_WORDS = 4;

  typedef struct packed {
    logic [15:0] frame;
    logic [15:0] line;
    logic [3:0]  seg;
    logic [11:0] len;
  } seg_desc_t;

  typedef enum logic [1:0] {W_SYNC, W_LINE, W_SKIP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_PAY}   r_state_e;

  // First segment of a frame carries the frame-start flag on its magic word.
  function automatic logic is_frame_start(input seg_desc_t d);
    return (d.line == 16'd0) && (d.seg == 4'd0);
  endfunction

endpackage

// File: rtl/cam_pkt_bank_ram.sv
// Two-bank pixel buffer: simple dual-port RAM, one write and one synchronous read port.
module cam_pkt_bank_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // rdata holds its value while re is low; the read FSM relies on that during stalls.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cam_line_packetizer.sv
// Splits camera lines into header-tagged segments, double-buffered, streamed out on valid/ready.
module cam_line_packetizer
  import cam_pkt_pkg::*;
#(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int PIX_PER_PKT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        vsync,
  input  logic        de,
  input  logic [15:0] pix_data,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] frame_id,
  output logic [15:0] drop_cnt,
  output logic        short_line
);

  localparam int          IW      = $clog2(PIX_PER_PKT);
  localparam int          AW      = IW + 1;
  localparam logic [11:0] SEG_MAX = 12'(PIX_PER_PKT);

  logic        vs_in_q, vs_dly_q, de_in_q, de_dly_q;
  logic [15:0] pix_in_q;
  logic        vs_rise, de_fall;

  w_state_e    wst_q, wst_d;
  logic [15:0] frame_id_q, frame_id_d, line_q, line_d, line_pix_q, line_pix_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [3:0]  seg_q, seg_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic        fill_q, fill_d, drop_q, drop_d, short_q, short_d;
  logic [1:0]  full_q, full_d, full_set, full_clr;
  seg_desc_t [1:0] desc_q, desc_d;

  r_state_e    rst_q, rst_d;
  logic        rd_bank_q, rd_bank_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [11:0] pay_idx_q, pay_idx_d, pay_nxt;
  logic [15:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  seg_desc_t   cur_desc, nxt_desc;

  logic          seg_end, wbank, wdrop;
  logic [11:0]   wcnt;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [15:0]   ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_in_q  <= 1'b0;
      vs_dly_q <= 1'b0;
      de_in_q  <= 1'b0;
      de_dly_q <= 1'b0;
      pix_in_q <= '0;
    end else begin
      vs_in_q  <= vsync;
      vs_dly_q <= vs_in_q;
      de_in_q  <= de;
      de_dly_q <= de_in_q;
      pix_in_q <= pix_data;
    end
  end

  assign vs_rise = vs_in_q & ~vs_dly_q;
  assign de_fall = de_dly_q & ~de_in_q;

  // Write side: fill banks from the registered pixel stream, commit or drop segments.
  always_comb begin
    wst_d      = wst_q;
    frame_id_d = frame_id_q;
    line_d     = line_q;
    seg_d      = seg_q;
    pix_cnt_d  = pix_cnt_q;
    line_pix_d = line_pix_q;
    fill_d     = fill_q;
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
    short_d    = short_q;
    desc_d     = desc_q;
    full_set   = '0;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    seg_end    = 1'b0;
    wcnt       = pix_cnt_q;
    wbank      = fill_q;
    wdrop      = drop_q;
    if (!enable) begin
      wst_d     = W_SYNC;
      pix_cnt_d = '0;
      drop_d    = 1'b0;
    end else begin
      if (wst_q == W_LINE) begin
        seg_end = (pix_cnt_q == SEG_MAX) || ((de_fall || vs_rise) && (pix_cnt_q != '0));
        if (seg_end) begin
          if (drop_q) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            full_set[fill_q]     = 1'b1;
            desc_d[fill_q].frame = frame_id_q;
            desc_d[fill_q].line  = line_q;
            desc_d[fill_q].seg   = seg_q;
            desc_d[fill_q].len   = pix_cnt_q;
            wbank                = ~fill_q;
            fill_d               = ~fill_q;
          end
          wcnt  = '0;
          wdrop = 1'b0;
          seg_d = seg_q + 4'd1;
        end
        if (de_in_q && !vs_rise) begin
          // The drop decision is made once, on the first pixel of a segment.
          if (wcnt == '0) wdrop = full_q[wbank];
          ram_we     = ~wdrop;
          ram_waddr  = {wbank, wcnt[IW-1:0]};
          wcnt       = wcnt + 12'd1;
          line_pix_d = line_pix_q + 16'd1;
        end
        pix_cnt_d = wcnt;
        drop_d    = wdrop;
        if (de_fall && !vs_rise) begin
          line_d     = line_q + 16'd1;
          seg_d      = '0;
          line_pix_d = '0;
          if (line_pix_q != 16'(H_ACTIVE)) short_d = 1'b1;
          if (32'(line_q) + 32'd1 >= 32'(V_ACTIVE)) wst_d = W_SKIP;
        end
      end
      if (vs_rise) begin
        wst_d      = W_LINE;
        frame_id_d = frame_id_q + 16'd1;
        line_d     = '0;
        seg_d      = '0;
        pix_cnt_d  = '0;
        line_pix_d = '0;
        drop_d     = 1'b0;
      end
    end
  end

  assign cur_desc = desc_q[rd_bank_q];
  assign nxt_desc = desc_q[~rd_bank_q];
  assign pay_nxt  = pay_idx_q + 12'd1;

  // Read side: header words then payload; one payload word is always prefetched in ram_rdata.
  always_comb begin
    rst_d     = rst_q;
    rd_bank_d = rd_bank_q;
    hdr_idx_d = hdr_idx_q;
    pay_idx_d = pay_idx_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    full_clr  = '0;
    ram_re    = 1'b0;
    ram_raddr = {rd_bank_q, pay_nxt[IW-1:0]};
    case (rst_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          tdata_d   = HDR_MAGIC;
          tvalid_d  = 1'b1;
          tuser_d   = is_frame_start(cur_desc);
          tlast_d   = 1'b0;
          hdr_idx_d = 2'd1;
          rst_d     = R_HDR;
        end
      end
      R_HDR: begin
        if (m_tready) begin
          tuser_d   = 1'b0;
          hdr_idx_d = hdr_idx_q + 2'd1;
          case (hdr_idx_q)
            2'd1:    tdata_d = cur_desc.frame;
            2'd2:    tdata_d = cur_desc.line;
            default: begin
              tdata_d   = {cur_desc.seg, cur_desc.len};
              ram_re    = 1'b1;
              ram_raddr = {rd_bank_q, {IW{1'b0}}};
              pay_idx_d = '0;
              if (hdr_idx_q == 2'(HDR_WORDS - 1)) rst_d = R_PAY;
            end
          endcase
        end
      end
      R_PAY: begin
        if (m_tready) begin
          if (tlast_q) begin
            full_clr[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
            tlast_d             = 1'b0;
            // Chain straight into the next buffered segment to avoid an idle bubble.
            if (full_q[~rd_bank_q]) begin
              tdata_d   = HDR_MAGIC;
              tuser_d   = is_frame_start(nxt_desc);
              hdr_idx_d = 2'd1;
              rst_d     = R_HDR;
            end else begin
              tvalid_d = 1'b0;
              rst_d    = R_IDLE;
            end
          end else begin
            tdata_d   = ram_rdata;
            tlast_d   = (pay_idx_q == cur_desc.len - 12'd1);
            ram_re    = 1'b1;
            pay_idx_d = pay_nxt;
          end
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  assign full_d = (full_q & ~full_clr) | full_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      wst_q      <= W_SYNC;
      frame_id_q <= '0;
      line_q     <= '0;
      seg_q      <= '0;
      pix_cnt_q  <= '0;
      line_pix_q <= '0;
      fill_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
      short_q    <= 1'b0;
      full_q     <= '0;
      desc_q     <= '0;
      rst_q      <= R_IDLE;
      rd_bank_q  <= 1'b0;
      hdr_idx_q  <= '0;
      pay_idx_q  <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
    end else begin
      wst_q      <= wst_d;
      frame_id_q <= frame_id_d;
      line_q     <= line_d;
      seg_q      <= seg_d;
      pix_cnt_q  <= pix_cnt_d;
      line_pix_q <= line_pix_d;
      fill_q     <= fill_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      short_q    <= short_d;
      full_q     <= full_d;
      desc_q     <= desc_d;
      rst_q      <= rst_d;
      rd_bank_q  <= rd_bank_d;
      hdr_idx_q  <= hdr_idx_d;
      pay_idx_q  <= pay_idx_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
    end
  end

  cam_pkt_bank_ram #(.AW(AW), .DW(16)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (pix_in_q),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign m_tdata    = tdata_q;
  assign m_tvalid   = tvalid_q;
  assign m_tlast    = tlast_q;
  assign m_tuser    = tuser_q;
  assign frame_id   = frame_id_q;
  assign drop_cnt   = drop_cnt_q;
  assign short_line = short_q;

endmodule

// File: tb/tb_cam_line_packetizer.sv
// Directed bench for cam_line_packetizer at 4x3 pixels, 2 pixels per segment.
module tb_cam_line_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        vsync = 1'b0;
  logic        de = 1'b0;
  logic [15:0] pix_data = '0;
  logic        m_tready = 1'b1;
  logic [15:0] m_tdata, frame_id, drop_cnt;
  logic        m_tvalid, m_tlast, m_tuser, short_line;

  cam_line_packetizer #(.H_ACTIVE(4), .V_ACTIVE(3), .PIX_PER_PKT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .vsync      (vsync),
    .de         (de),
    .pix_data   (pix_data),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .frame_id   (frame_id),
    .drop_cnt   (drop_cnt),
    .short_line (short_line)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  int          got_rd = 0;
  int          stab_bad = 0;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_word = '0;

  // Capture accepted words ({user,last,data}) and flag any change while stalled.
  always @(negedge clk) begin
    if (!rst && prev_stall && ({m_tvalid, m_tuser, m_tlast, m_tdata} != prev_word)) stab_bad++;
    if (m_tvalid && m_tready) got_q.push_back({m_tuser, m_tlast, m_tdata});
    prev_stall = m_tvalid && !m_tready && !rst;
    prev_word  = {m_tvalid, m_tuser, m_tlast, m_tdata};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_line(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      de       = 1'b1;
      pix_data = base + 16'(i);
      cyc(1);
    end
    de       = 1'b0;
    pix_data = '0;
    cyc(1);
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    cyc(3);
  endtask

  task automatic exp_seg(input logic [15:0] fr, input logic [15:0] ln, input logic [3:0] sg,
                         input logic [11:0] len, input logic [15:0] base, input logic user);
    logic [15:0] v;
    logic        l;
    exp_q.push_back({user, 1'b0, 16'hA55A});
    exp_q.push_back({2'b00, fr});
    exp_q.push_back({2'b00, ln});
    exp_q.push_back({2'b00, sg, len});
    for (int i = 0; i < int'(len); i++) begin
      v = base + 16'(i);
      l = (i == int'(len) - 1);
      exp_q.push_back({1'b0, l, v});
    end
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    n = got_q.size() - got_rd;
    chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < n) chk($sformatf("%s_w%0d", tag, i), 32'(got_q[got_rd + i]), 32'(exp_q[i]));
    chk({tag, "_stable"}, 32'(stab_bad), 32'd0);
    got_rd = got_rd + n;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(3);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tuser", 32'(m_tuser), 32'd0);
    chk("rst_frame_id", 32'(frame_id), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_short", 32'(short_line), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;
    cyc(2);

    // Full frame of 3 lines x 4 px, plus a 4th line beyond V_ACTIVE that must vanish.
    vs_pulse();
    chk("t1_frame_id", 32'(frame_id), 32'd1);
    for (int ln = 0; ln < 4; ln++) begin
      send_line(4, 16'h1000 + 16'(ln * 16));
      cyc(20);
    end
    for (int ln = 0; ln < 3; ln++) begin
      exp_seg(16'd1, 16'(ln), 4'd0, 12'd2, 16'h1000 + 16'(ln * 16), ln == 0);
      exp_seg(16'd1, 16'(ln), 4'd1, 12'd2, 16'h1002 + 16'(ln * 16), 1'b0);
    end
    cyc(10);
    cmp_stream("t1");
    chk("t1_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t1_short", 32'(short_line), 32'd0);

    // Output blocked for 3 full segments: two buffered, third dropped.
    m_tready = 1'b0;
    vs_pulse();
    chk("t2_frame_id", 32'(frame_id), 32'd2);
    send_line(6, 16'h2000);
    cyc(10);
    chk("t2_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("t2_hold_valid", 32'(m_tvalid), 32'd1);
    chk("t2_hold_data", 32'(m_tdata), 32'hA55A);
    chk("t2_hold_user", 32'(m_tuser), 32'd1);
    chk("t2_short", 32'(short_line), 32'd1);
    for (int i = 0; i < 80; i++) begin
      m_tready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    m_tready = 1'b1;
    cyc(10);
    exp_seg(16'd2, 16'd0, 4'd0, 12'd2, 16'h2000, 1'b1);
    exp_seg(16'd2, 16'd0, 4'd1, 12'd2, 16'h2002, 1'b0);
    cmp_stream("t2");

    // 3 px line gives a partial tail; 5 px line overruns the banks and loses its tail.
    send_line(3, 16'h2100);
    cyc(30);
    send_line(5, 16'h2200);
    cyc(30);
    exp_seg(16'd2, 16'd1, 4'd0, 12'd2, 16'h2100, 1'b0);
    exp_seg(16'd2, 16'd1, 4'd1, 12'd1, 16'h2102, 1'b0);
    exp_seg(16'd2, 16'd2, 4'd0, 12'd2, 16'h2200, 1'b0);
    exp_seg(16'd2, 16'd2, 4'd1, 12'd2, 16'h2202, 1'b0);
    cmp_stream("t3");
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd2);

    // enable drops mid-line: partial discarded, nothing until the next vsync.
    de = 1'b1; pix_data = 16'h3000; cyc(1);
    pix_data = 16'h3001; cyc(1);
    enable = 1'b0; pix_data = 16'h3002; cyc(1);
    pix_data = 16'h3003; cyc(1);
    enable = 1'b1; pix_data = 16'h3004; cyc(1);
    de = 1'b0; pix_data = '0;
    cyc(30);
    send_line(4, 16'h30F0);
    cyc(30);
    chk("t4_quiet", 32'(got_q.size() - got_rd), 32'd0);
    chk("t4_no_valid", 32'(m_tvalid), 32'd0);
    chk("t4_frame_hold", 32'(frame_id), 32'd2);
    chk("t4_drop_hold", 32'(drop_cnt), 32'd2);
    vs_pulse();
    chk("t4_frame_id", 32'(frame_id), 32'd3);
    send_line(4, 16'h3100);
    cyc(30);
    exp_seg(16'd3, 16'd0, 4'd0, 12'd2, 16'h3100, 1'b1);
    exp_seg(16'd3, 16'd0, 4'd1, 12'd2, 16'h3102, 1'b0);
    cmp_stream("t4");

    // Reset while a payload is streaming, then a clean frame.
    vs_pulse();
    send_line(4, 16'h4000);
    for (int i = 0; i < 40 && (got_q.size() - got_rd) < 6; i++) cyc(1);
    chk("t5_reach_payload", 32'((got_q.size() - got_rd) >= 6), 32'd1);
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("t5_rst_frame_id", 32'(frame_id), 32'd0);
    chk("t5_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t5_rst_short", 32'(short_line), 32'd0);
    rst = 1'b0;
    cyc(2);
    got_rd = got_q.size();
    exp_q.delete();
    vs_pulse();
    chk("t5_frame_id", 32'(frame_id), 32'd1);
    send_line(4, 16'h5000);
    cyc(30);
    exp_seg(16'd1, 16'd0, 4'd0, 12'd2, 16'h5000, 1'b1);
    exp_seg(16'd1, 16'd0, 4'd1, 12'd2, 16'h5002, 1'b0);
    cmp_stream("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
